nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/nonce_scheduler.sv | 167 ++++++++++++++++
 tb/tb_nonce_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - hands out nonce chunks to hash cores, detects golden nonce or exhaustion
module nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blkValid,
    input  logic [351:0]            blkState,
    output logic                    blkTake,
    input  logic [NUM_CORES-1:0]    coreReq,
    output logic [NUM_CORES-1:0]    coreGrant,
    output logic [31:0]             coreNonceBase,
    output logic [351:0]            coreState,
    input  logic [NUM_CORES-1:0]    coreDone,
    input  logic [NUM_CORES-1:0]    coreFound,
    input  logic [32*NUM_CORES-1:0] coreNonce,
    output logic                    coreAbort,
    output logic                    foundValid,
    output logic [31:0]             foundNonce,
    output logic                    exhausted
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t                 state, state_next;
    logic [32:0]            counter;
    logic [32:0]            counter_inc;
    logic [NUM_CORES-1:0]   busy;
    logic [PW-1:0]          rr_ptr;
    logic                   cause_found;
    logic [351:0]           core_state_q;
    logic                   core_abort_q;
    logic                   found_valid_q;
    logic [31:0]            found_nonce_q;
    logic                   exhausted_q;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   found_hits;
    logic                   found_any;
    logic [31:0]            found_sel;
    logic                   grant_any;
    logic                   grant_ok;
    logic [PW-1:0]          grant_idx;
    logic [NUM_CORES-1:0]   grant_vec;
    logic [PW:0]            rr_sum;

    assign counter_inc = counter + (33'd1 << CHUNK_LOG2);

    // Found requests outrank grants; lowest busy finder wins.
    always_comb begin
        eligible   = (state == DISPATCH) ? (coreReq & ~busy) : '0;
        found_hits = (state == DISPATCH) ? (coreFound & busy) : '0;
        found_any  = 1'b0;
        found_sel  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found_any && found_hits[i]) begin
                found_any = 1'b1;
                found_sel = coreNonce[32*i +: 32];
            end
        end
        grant_any = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rr_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (rr_sum >= (PW+1)'(NUM_CORES))
                rr_sum = rr_sum - (PW+1)'(NUM_CORES);
            if (!grant_any && eligible[rr_sum[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = rr_sum[PW-1:0];
            end
        end
        grant_ok  = grant_any && !found_any;
        grant_vec = grant_ok ? (NUM_CORES'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        blkTake    = 1'b0;
        case (state)
            IDLE: begin
                blkTake = blkValid && !rst;
                if (blkValid)
                    state_next = DISPATCH;
            end
            DISPATCH: begin
                if (found_any || (grant_ok && counter_inc[32]))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (busy == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter       <= '0;
            busy          <= '0;
            rr_ptr        <= '0;
            cause_found   <= 1'b0;
            core_state_q  <= '0;
            core_abort_q  <= 1'b0;
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
        end else begin
            core_abort_q  <= 1'b0;
            found_valid_q <= 1'b0;
            exhausted_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (blkValid) begin
                        core_state_q <= blkState;
                        counter      <= '0;
                        busy         <= '0;
                        rr_ptr       <= '0;
                    end
                end
                DISPATCH: begin
                    if (found_any) begin
                        found_nonce_q <= found_sel;
                        found_valid_q <= 1'b1;
                        core_abort_q  <= 1'b1;
                        busy          <= '0;
                        cause_found   <= 1'b1;
                    end else begin
                        // OR-ing the grant last lets a same-cycle set beat a done
                        busy <= (busy & ~coreDone) | grant_vec;
                        if (grant_ok) begin
                            counter     <= counter_inc;
                            rr_ptr      <= (grant_idx == PW'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
                            cause_found <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    busy <= busy & ~coreDone;
                    if (busy == '0)
                        exhausted_q <= !cause_found;
                end
                default: ;
            endcase
        end
    end

    assign coreGrant     = grant_vec;
    assign coreNonceBase = counter[31:0];
    assign coreState     = core_state_q;
    assign coreAbort     = core_abort_q;
    assign foundValid    = found_valid_q;
    assign foundNonce    = found_nonce_q;
    assign exhausted     = exhausted_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - directed checks of block load, round-robin, found, exhaust and reset
module tb_nonce_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int compared = 0;
    int fails    = 0;

    // Instance A: default parameters
    logic         a_blkValid, a_blkTake, a_coreAbort, a_foundValid, a_exhausted;
    logic [351:0] a_blkState, a_coreState;
    logic [3:0]   a_coreReq, a_coreGrant, a_coreDone, a_coreFound;
    logic [31:0]  a_coreNonceBase, a_foundNonce;
    logic [127:0] a_coreNonce;

    // Instances B and C: two cores, 64K-nonce chunks
    logic         b_blkValid, b_blkTake, b_coreAbort, b_foundValid, b_exhausted;
    logic [351:0] b_coreState;
    logic [1:0]   b_coreReq, b_coreGrant, b_coreDone, b_coreFound;
    logic [31:0]  b_coreNonceBase, b_foundNonce;
    logic [63:0]  b_coreNonce;
    logic         c_blkTake, c_coreAbort, c_foundValid, c_exhausted;
    logic [351:0] c_coreState;
    logic [1:0]   c_coreGrant, c_coreDone, c_coreFound;
    logic [31:0]  c_coreNonceBase, c_foundNonce;
    logic [63:0]  c_coreNonce;

    nonce_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(8)) u_a (
        .clk(clk), .rst(rst), .blkValid(a_blkValid), .blkState(a_blkState), .blkTake(a_blkTake),
        .coreReq(a_coreReq), .coreGrant(a_coreGrant), .coreNonceBase(a_coreNonceBase),
        .coreState(a_coreState), .coreDone(a_coreDone), .coreFound(a_coreFound),
        .coreNonce(a_coreNonce), .coreAbort(a_coreAbort), .foundValid(a_foundValid),
        .foundNonce(a_foundNonce), .exhausted(a_exhausted)
    );

    nonce_scheduler #(.NUM_CORES(2), .CHUNK_LOG2(16)) u_b (
        .clk(clk), .rst(rst), .blkValid(b_blkValid), .blkState('0), .blkTake(b_blkTake),
        .coreReq(b_coreReq), .coreGrant(b_coreGrant), .coreNonceBase(b_coreNonceBase),
        .coreState(b_coreState), .coreDone(b_coreDone), .coreFound(b_coreFound),
        .coreNonce(b_coreNonce), .coreAbort(b_coreAbort), .foundValid(b_foundValid),
        .foundNonce(b_foundNonce), .exhausted(b_exhausted)
    );

    nonce_scheduler #(.NUM_CORES(2), .CHUNK_LOG2(16)) u_c (
        .clk(clk), .rst(rst), .blkValid(b_blkValid), .blkState('0), .blkTake(c_blkTake),
        .coreReq(b_coreReq), .coreGrant(c_coreGrant), .coreNonceBase(c_coreNonceBase),
        .coreState(c_coreState), .coreDone(c_coreDone), .coreFound(c_coreFound),
        .coreNonce(c_coreNonce), .coreAbort(c_coreAbort), .foundValid(c_foundValid),
        .foundNonce(c_foundNonce), .exhausted(c_exhausted)
    );

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [351:0] pat1, pat2;
    logic [1:0]   b_prev, c_prev;

    initial begin
        pat1 = {11{32'hC0DE_0001}};
        pat2 = {11{32'h5A5A_F00D}};
        rst = 1'b1;
        a_blkValid = 1'b1; a_blkState = pat1; a_coreReq = '0; a_coreDone = '0;
        a_coreFound = '0;  a_coreNonce = {32'h33, 32'hBB, 32'hAA, 32'h11};
        b_blkValid = 1'b0; b_coreReq = '0; b_coreDone = '0; b_coreFound = '0;
        b_coreNonce = '0;  c_coreDone = '0; c_coreFound = '0;
        c_coreNonce = {32'h0000_0001, 32'hDEAD_BEEF};

        tick;
        chk("rst_blktake",  a_blkTake,   1'b0);
        chk("rst_grant",    a_coreGrant, 4'b0);
        chk("rst_state",    a_coreState, '0);
        chk("rst_fnonce",   a_foundNonce, 32'h0);
        chk("rst_pulses",   {a_coreAbort, a_foundValid, a_exhausted}, 3'b0);

        rst = 1'b0;
        #1;
        chk("load_take", a_blkTake, 1'b1);
        tick;
        a_blkValid = 1'b0;
        #1;
        chk("load_state",   a_coreState, pat1);
        chk("load_no_take", a_blkTake, 1'b0);

        a_coreReq = 4'b1111;
        #1;
        chk("rr_g0", a_coreGrant, 4'b0001); chk("rr_b0", a_coreNonceBase, 32'h000);
        tick;
        chk("rr_g1", a_coreGrant, 4'b0010); chk("rr_b1", a_coreNonceBase, 32'h100);
        tick;
        chk("rr_g2", a_coreGrant, 4'b0100); chk("rr_b2", a_coreNonceBase, 32'h200);
        tick;
        chk("rr_g3", a_coreGrant, 4'b1000); chk("rr_b3", a_coreNonceBase, 32'h300);
        tick;
        chk("rr_allbusy", a_coreGrant, 4'b0000);
        a_coreDone = 4'b0010;
        #1;
        chk("rr_done_cycle", a_coreGrant, 4'b0000);
        tick;
        a_coreDone = '0;
        #1;
        chk("rr_regrant", a_coreGrant, 4'b0010); chk("rr_b4", a_coreNonceBase, 32'h400);
        tick;

        a_coreDone = 4'b0001;
        tick;
        a_coreDone = '0; a_coreFound = 4'b0110;
        #1;
        chk("found_nogrant", a_coreGrant, 4'b0000);
        tick;
        a_coreFound = '0;
        chk("found_valid", a_foundValid, 1'b1);
        chk("found_abort", a_coreAbort, 1'b1);
        chk("found_nonce", a_foundNonce, 32'hAA);
        chk("found_exh0",  a_exhausted, 1'b0);
        chk("found_drain_grant", a_coreGrant, 4'b0000);
        tick;
        a_blkValid = 1'b1; a_blkState = pat2;
        #1;
        chk("found_valid_off", a_foundValid, 1'b0);
        chk("found_abort_off", a_coreAbort, 1'b0);
        chk("found_exh1",      a_exhausted, 1'b0);
        chk("found_held",      a_foundNonce, 32'hAA);
        chk("found_idle_take", a_blkTake, 1'b1);

        tick;
        a_blkValid = 1'b0; a_blkState = pat1;
        #1;
        chk("blk2_state", a_coreState, pat2);
        chk("blk2_rr0",   a_coreGrant, 4'b0001);
        chk("blk2_base0", a_coreNonceBase, 32'h0);
        tick;
        chk("blk2_g1", a_coreGrant, 4'b0010);
        #3;
        rst = 1'b1;
        a_blkValid = 1'b1;
        #1;
        chk("arst_grant",  a_coreGrant, 4'b0);
        chk("arst_take",   a_blkTake, 1'b0);
        chk("arst_state",  a_coreState, '0);
        chk("arst_base",   a_coreNonceBase, 32'h0);
        chk("arst_fnonce", a_foundNonce, 32'h0);
        chk("arst_pulses", {a_coreAbort, a_foundValid, a_exhausted}, 3'b0);
        rst = 1'b0;
        #1;
        chk("arst_rel_take", a_blkTake, 1'b1);
        tick;
        a_blkValid = 1'b0; a_coreReq = '0;
        chk("arst_reload", a_coreState, pat1);
        chk("arst_rel_pulses", {a_coreAbort, a_foundValid, a_exhausted}, 3'b0);

        b_blkValid = 1'b1;
        tick;
        b_blkValid = 1'b0; b_coreReq = 2'b11;
        b_prev = '0; c_prev = '0;
        for (int k = 0; k < 65536; k++) begin
            b_coreDone = b_prev;
            c_coreDone = c_prev;
            if (k == 65535)
                c_coreFound = 2'b01;
            #1;
            if (k == 0) begin
                chk("ex_g0", b_coreGrant, 2'b01); chk("ex_b0", b_coreNonceBase, 32'h0);
            end
            if (k == 1) begin
                chk("ex_g1", b_coreGrant, 2'b10); chk("ex_b1", b_coreNonceBase, 32'h0001_0000);
            end
            if (k == 65535) begin
                chk("ex_glast", b_coreGrant, 2'b10);
                chk("ex_blast", b_coreNonceBase, 32'hFFFF_0000);
                chk("sim_nogrant", c_coreGrant, 2'b00);
            end
            b_prev = b_coreGrant;
            c_prev = c_coreGrant;
            tick;
        end
        c_coreFound = '0; c_coreDone = '0; b_coreDone = '0;
        #1;
        chk("ex_drain_grant", b_coreGrant, 2'b00);
        chk("ex_wait0",   b_exhausted, 1'b0);
        chk("sim_valid",  c_foundValid, 1'b1);
        chk("sim_abort",  c_coreAbort, 1'b1);
        chk("sim_nonce",  c_foundNonce, 32'hDEAD_BEEF);
        tick;
        chk("ex_wait1",   b_exhausted, 1'b0);
        chk("sim_exh0",   c_exhausted, 1'b0);
        tick;
        chk("ex_wait2",   b_exhausted, 1'b0);
        b_coreDone = b_prev;
        tick;
        b_coreDone = '0;
        chk("ex_wait3",   b_exhausted, 1'b0);
        chk("sim_exh1",   c_exhausted, 1'b0);
        tick;
        chk("ex_pulse",   b_exhausted, 1'b1);
        chk("ex_no_found", b_foundValid, 1'b0);
        chk("sim_exh2",   c_exhausted, 1'b0);
        tick;
        chk("ex_pulse_off", b_exhausted, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
